// File: rtl/lockin_pkg.sv
// Shared types and constants for the lock-in polar conversion stage.
package lockin_pkg;

  localparam int DATA_W = 64;
  localparam int ANG_W  = 32;
  localparam int CW     = 67;

  typedef enum logic [1:0] {IDLE, LOAD, ROT, DONE} state_t;

  // round(atan(2^-i) * 2^32 / 2pi)
  localparam logic [ANG_W-1:0] ATAN_LUT [0:31] = '{
    32'h2000_0000, 32'h12E4_051E, 32'h09FB_385B, 32'h0511_11D4,
    32'h028B_0D43, 32'h0145_D7E1, 32'h00A2_F61E, 32'h0051_7C55,
    32'h0028_BE53, 32'h0014_5F2F, 32'h000A_2F98, 32'h0005_17CC,
    32'h0002_8BE6, 32'h0001_45F3, 32'h0000_A2FA, 32'h0000_517D,
    32'h0000_28BE, 32'h0000_145F, 32'h0000_0A30, 32'h0000_0518,
    32'h0000_028C, 32'h0000_0146, 32'h0000_00A3, 32'h0000_0051,
    32'h0000_0029, 32'h0000_0014, 32'h0000_000A, 32'h0000_0005,
    32'h0000_0003, 32'h0000_0001, 32'h0000_0001, 32'h0000_0000
  };

endpackage

// File: rtl/lockin_polar_cordic.sv
// Pairs fase/cuad lock-in results and converts them to magnitude/angle with
// an iterative vectoring CORDIC sharing one add/sub stage.
module lockin_polar_cordic
  import lockin_pkg::*;
#(
  parameter int ITER      = 32,
  parameter int OUT_SHIFT = 2
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     enable,
  input  logic signed [DATA_W-1:0] fase_in,
  input  logic                     fase_in_valid,
  input  logic signed [DATA_W-1:0] cuad_in,
  input  logic                     cuad_in_valid,
  output logic        [DATA_W-1:0] mag_out,
  output logic signed [ANG_W-1:0]  ang_out,
  output logic                     out_valid,
  output logic                     busy,
  output logic                     overrun
);

  localparam logic [4:0] LAST_IT = 5'(ITER - 1);

  state_t state, state_nx;

  logic signed [DATA_W-1:0] fase_hold, cuad_hold;
  logic                     pend_f, pend_c;
  logic signed [CW-1:0]     x_r, y_r;
  logic signed [CW-1:0]     x_sh, y_sh, x_nx, y_nx;
  logic        [ANG_W-1:0]  z_r, z_nx, atan_i;
  logic        [4:0]        iter_cnt;
  logic                     fv, cv, consume, last;

  function automatic logic [DATA_W-1:0] sat_mag(input logic signed [CW-1:0] v);
    logic signed [CW-1:0] s;
    s = v >>> OUT_SHIFT;
    if (s[CW-1])
      return '0;
    else if (|s[CW-2:DATA_W])
      return '1;
    else
      return s[DATA_W-1:0];
  endfunction

  assign fv      = enable & fase_in_valid;
  assign cv      = enable & cuad_in_valid;
  assign consume = (state == IDLE) & pend_f & pend_c;
  assign last    = (iter_cnt == LAST_IT);

  assign out_valid = (state == DONE);
  assign busy      = (state != IDLE) | (pend_f & pend_c);

  always_ff @(posedge clk) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (consume) state_nx = LOAD;
      LOAD:    state_nx = ROT;
      ROT:     if (last) state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Micro-rotation: both updates use the pre-update X and Y.
  always_comb begin
    x_sh   = x_r >>> iter_cnt;
    y_sh   = y_r >>> iter_cnt;
    atan_i = ATAN_LUT[iter_cnt];
    if (y_r[CW-1]) begin
      x_nx = x_r - y_sh;
      y_nx = y_r + x_sh;
      z_nx = z_r - atan_i;
    end else begin
      x_nx = x_r + y_sh;
      y_nx = y_r - x_sh;
      z_nx = z_r + atan_i;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      pend_f   <= 1'b0;
      pend_c   <= 1'b0;
      overrun  <= 1'b0;
      iter_cnt <= '0;
      mag_out  <= '0;
      ang_out  <= '0;
    end else begin
      pend_f  <= fv | (pend_f & ~consume);
      pend_c  <= cv | (pend_c & ~consume);
      overrun <= overrun | (fv & pend_f & ~consume) | (cv & pend_c & ~consume);
      if (state == LOAD)
        iter_cnt <= '0;
      else if (state == ROT)
        iter_cnt <= iter_cnt + 5'd1;
      if ((state == ROT) && last) begin
        mag_out <= sat_mag(x_nx);
        ang_out <= z_nx;
      end
    end
  end

  // Data path: operands snapshot at pairing so a fresh capture cannot disturb them.
  always_ff @(posedge clk) begin
    if (fv) fase_hold <= fase_in;
    if (cv) cuad_hold <= cuad_in;
    case (state)
      IDLE: if (consume) begin
        x_r <= {{(CW-DATA_W){fase_hold[DATA_W-1]}}, fase_hold};
        y_r <= {{(CW-DATA_W){cuad_hold[DATA_W-1]}}, cuad_hold};
      end
      LOAD: begin
        if (x_r[CW-1]) begin
          x_r <= -x_r;
          y_r <= -y_r;
          z_r <= 32'h8000_0000;
        end else begin
          z_r <= '0;
        end
      end
      ROT: begin
        x_r <= x_nx;
        y_r <= y_nx;
        z_r <= z_nx;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_lockin_polar_cordic.sv
// Scoreboard bench for lockin_polar_cordic against a real-valued polar reference.
module tb_lockin_polar_cordic;

  localparam int ITER      = 32;
  localparam int OUT_SHIFT = 2;

  logic               clk = 1'b0;
  logic               reset_n = 1'b0;
  logic               enable = 1'b1;
  logic signed [63:0] fase_in = '0;
  logic               fase_in_valid = 1'b0;
  logic signed [63:0] cuad_in = '0;
  logic               cuad_in_valid = 1'b0;
  logic        [63:0] mag_out;
  logic signed [31:0] ang_out;
  logic               out_valid;
  logic               busy;
  logic               overrun;

  lockin_polar_cordic #(.ITER(ITER), .OUT_SHIFT(OUT_SHIFT)) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .enable        (enable),
    .fase_in       (fase_in),
    .fase_in_valid (fase_in_valid),
    .cuad_in       (cuad_in),
    .cuad_in_valid (cuad_in_valid),
    .mag_out       (mag_out),
    .ang_out       (ang_out),
    .out_valid     (out_valid),
    .busy          (busy),
    .overrun       (overrun)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] mag;
    logic [63:0] mag_tol;
    logic [31:0] ang;
    int          cyc;
    bit          chk_lat;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;
  real  an_gain = 1.0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp,
                       input logic [63:0] tol, input bit ang);
    logic [63:0] d;
    logic [31:0] d32;
    n_checks++;
    if (ang) begin
      d32 = got[31:0] - exp[31:0];
      if (d32[31]) d32 = -d32;
      d = {32'b0, d32};
    end else begin
      d = (got > exp) ? got - exp : exp - got;
    end
    if (d > tol) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (tol %0d)", tag, got, exp, tol);
    end
  endtask

  always @(negedge clk) begin
    if (reset_n && out_valid) begin
      if (sb.size() == 0) begin
        check("unexpected_out_valid", 64'd1, 64'd0, 64'd0, 1'b0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("mag", mag_out, e.mag, e.mag_tol, 1'b0);
        check("ang", {32'b0, ang_out}, {32'b0, e.ang}, 64'd16, 1'b1);
        if (e.chk_lat) check("latency", 64'(cyc), 64'(e.cyc), 64'd0, 1'b0);
      end
    end
  end

  task automatic send(input bit fv, input logic signed [63:0] f,
                      input bit cv, input logic signed [63:0] c);
    @(negedge clk);
    fase_in = f; fase_in_valid = fv;
    cuad_in = c; cuad_in_valid = cv;
    @(posedge clk);
    #1;
    fase_in_valid = 1'b0;
    cuad_in_valid = 1'b0;
  endtask

  task automatic push_exp(input logic signed [63:0] f, input logic signed [63:0] c,
                          input bit chk_lat);
    exp_t  e;
    real   fr, cr, m, a;
    longint la;
    fr = real'(f);
    cr = real'(c);
    m  = $sqrt(fr * fr + cr * cr) * an_gain / real'(1 << OUT_SHIFT);
    a  = $atan2(cr, fr) * 4294967296.0 / (2.0 * 3.14159265358979323846);
    la = longint'(a);
    e.mag     = 64'(longint'(m));
    e.mag_tol = 64'd32 + 64'(longint'(m / 68719476736.0));
    e.ang     = la[31:0];
    e.cyc     = cyc + ITER + 2;
    e.chk_lat = chk_lat;
    sb.push_back(e);
  endtask

  task automatic drain(input int max_cyc);
    int n;
    n = 0;
    while (sb.size() != 0 && n < max_cyc) begin
      @(posedge clk);
      n++;
    end
    if (sb.size() != 0) begin
      check("drain_timeout", 64'(sb.size()), 64'd0, 64'd0, 1'b0);
      sb.delete();
    end
    repeat (3) @(posedge clk);
  endtask

  task automatic pair(input logic signed [63:0] f, input logic signed [63:0] c);
    send(1'b1, f, 1'b1, c);
    push_exp(f, c, 1'b1);
    drain(200);
  endtask

  initial begin
    real p;
    p = 1.0;
    for (int i = 0; i < ITER; i++) begin
      an_gain = an_gain * $sqrt(1.0 + p);
      p = p / 4.0;
    end

    repeat (3) @(posedge clk);
    #1;
    check("rst_mag", mag_out, 64'd0, 64'd0, 1'b0);
    check("rst_ang", {32'b0, ang_out}, 64'd0, 64'd0, 1'b0);
    check("rst_out_valid", {63'b0, out_valid}, 64'd0, 64'd0, 1'b0);
    check("rst_busy", {63'b0, busy}, 64'd0, 64'd0, 1'b0);
    check("rst_overrun", {63'b0, overrun}, 64'd0, 64'd0, 1'b0);
    reset_n = 1'b1;
    repeat (2) @(posedge clk);

    pair(64'sd1 <<< 40, 64'sd0);
    check("no_overrun", {63'b0, overrun}, 64'd0, 64'd0, 1'b0);

    send(1'b0, 64'sd0, 1'b1, 64'sd1 <<< 40);
    repeat (4) @(negedge clk);
    send(1'b1, 64'sd0, 1'b0, 64'sd0);
    push_exp(64'sd0, 64'sd1 <<< 40, 1'b1);
    drain(200);

    pair(-(64'sd1 <<< 40), 64'sd0);
    pair(-(64'sd1 <<< 40), -(64'sd1 <<< 40));
    pair(64'sh8000_0000_0000_0000, 64'sh8000_0000_0000_0000);
    pair(64'sd12345678901, -64'sd98765432109);
    pair(64'sh7FFF_FFFF_FFFF_FFFF, 64'sh7FFF_FFFF_FFFF_FFFF);

    enable = 1'b0;
    send(1'b1, 64'sd1 <<< 30, 1'b1, 64'sd1 <<< 30);
    enable = 1'b1;
    check("en0_busy", {63'b0, busy}, 64'd0, 64'd0, 1'b0);
    repeat (ITER + 10) @(posedge clk);

    send(1'b1, 64'sd777, 1'b0, 64'sd0);
    send(1'b1, 64'sd3 <<< 38, 1'b0, 64'sd0);
    send(1'b0, 64'sd0, 1'b1, -(64'sd5 <<< 37));
    push_exp(64'sd3 <<< 38, -(64'sd5 <<< 37), 1'b1);
    check("overrun_set", {63'b0, overrun}, 64'd1, 64'd0, 1'b0);
    drain(200);

    send(1'b1, 64'sd1 <<< 45, 1'b1, 64'sd1 <<< 44);
    push_exp(64'sd1 <<< 45, 64'sd1 <<< 44, 1'b1);
    repeat (10) @(posedge clk);
    send(1'b1, -(64'sd9 <<< 41), 1'b1, 64'sd7 <<< 40);
    push_exp(-(64'sd9 <<< 41), 64'sd7 <<< 40, 1'b0);
    drain(400);

    send(1'b1, 64'sd1 <<< 42, 1'b1, 64'sd1 <<< 41);
    repeat (12) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b0;
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    sb.delete();
    check("rst_mid_busy", {63'b0, busy}, 64'd0, 64'd0, 1'b0);
    check("rst_mid_overrun", {63'b0, overrun}, 64'd0, 64'd0, 1'b0);
    repeat (ITER + 10) @(posedge clk);

    pair(64'sd6 <<< 39, -(64'sd2 <<< 39));

    check("sb_empty", 64'(sb.size()), 64'd0, 64'd0, 1'b0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1);
  end

endmodule
